// File: rtl/ppu_vram_responder.sv
// Memory side of the PPU VRAM bus: pattern, mirrored 2 KB nametable and 32-byte palette storage.
// Nametable and palette RAM are cleared after reset, and accesses are held off until the clear finishes.
module ppu_vram_responder #(
    parameter bit         CHR_WRITABLE = 1'b1,
    parameter bit         INIT_CLEAR   = 1'b1,
    parameter logic [7:0] CLEAR_VALUE  = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] ppu2vram_addr,
    input  logic [7:0]  ppu2vram_data,
    input  logic        ppu2vram_wr,
    input  logic        ppu2vram_rd,
    input  logic [1:0]  mirror_mode,
    output logic [7:0]  vram2ppu_data,
    output logic        vram_rd_valid,
    output logic        vram_ready,
    output logic        vram_err
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_q, err_d;

    logic [7:0]  nt_mem  [2048];
    logic [5:0]  pal_mem [32];

    logic        is_pat, is_pal, tbit;
    logic [12:0] pat_idx;
    logic [4:0]  pal_idx;
    logic [10:0] nt_idx;
    logic [7:0]  pat_rdata, rd_mux;
    logic        clear_go, wr_go;

    always_comb begin
        is_pat  = ~ppu2vram_addr[13];
        is_pal  = (ppu2vram_addr[13:8] == 6'h3F);
        pat_idx = ppu2vram_addr[12:0];
        pal_idx = ppu2vram_addr[4:0];
        // Entry 0 of each sprite palette aliases the matching background entry.
        if (ppu2vram_addr[1:0] == 2'b00) begin
            pal_idx[4] = 1'b0;
        end
        unique case (mirror_mode)
            2'd0:    tbit = ppu2vram_addr[11];
            2'd1:    tbit = ppu2vram_addr[10];
            2'd2:    tbit = 1'b0;
            default: tbit = 1'b1;
        endcase
        nt_idx = {tbit, ppu2vram_addr[9:0]};
    end

    assign clear_go = (state_q == S_CLEAR) && !reset;
    assign wr_go    = (state_q == S_READY) && ppu2vram_wr && !reset;

    generate
        if (CHR_WRITABLE) begin : g_chr_ram
            logic [7:0] pat_mem [8192];
            always_ff @(posedge clock) begin
                if (wr_go && is_pat) begin
                    pat_mem[pat_idx] <= ppu2vram_data;
                end
            end
            assign pat_rdata = pat_mem[pat_idx];
        end else begin : g_chr_rom
            // No CHR image is loaded in the read-only build; pattern space reads as zero.
            assign pat_rdata = '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (clear_go) begin
            nt_mem[cnt_q] <= CLEAR_VALUE;
            if (cnt_q[10:5] == '0) begin
                pal_mem[cnt_q[4:0]] <= '0;
            end
        end else if (wr_go && !is_pat) begin
            if (is_pal) begin
                pal_mem[pal_idx] <= ppu2vram_data[5:0];
            end else begin
                nt_mem[nt_idx] <= ppu2vram_data;
            end
        end
    end

    always_comb begin
        if (is_pat) begin
            rd_mux = pat_rdata;
        end else if (is_pal) begin
            rd_mux = {2'b00, pal_mem[pal_idx]};
        end else begin
            rd_mux = nt_mem[nt_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == 11'd2047) begin
                    state_d = S_READY;
                end
                if (ppu2vram_rd || ppu2vram_wr) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                if (ppu2vram_wr) begin
                    if (ppu2vram_rd || (is_pat && !CHR_WRITABLE)) begin
                        err_d = 1'b1;
                    end
                end else if (ppu2vram_rd) begin
                    rdata_d    = rd_mux;
                    rd_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT_CLEAR ? S_CLEAR : S_READY;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign vram2ppu_data = rdata_q;
    assign vram_rd_valid = rd_valid_q;
    assign vram_ready    = (state_q == S_READY);
    assign vram_err      = err_q;

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed vector table plus hand-written sequences for clear timing, hazards, reset restart
// and a read-only pattern build, followed by random accesses checked against a model.
module tb_ppu_vram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  rdata;
    logic        rvalid, ready, err;

    logic        ro_rst = 1'b1;
    logic [13:0] ro_addr = '0;
    logic [7:0]  ro_wdata = '0;
    logic        ro_wr = 1'b0;
    logic        ro_rd = 1'b0;
    logic [7:0]  ro_rdata;
    logic        ro_rvalid, ro_ready, ro_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ppu_vram_responder #(.CHR_WRITABLE(1'b1), .INIT_CLEAR(1'b1), .CLEAR_VALUE(8'h00)) u_dut (
        .clock(clk), .reset(rst), .ppu2vram_addr(addr), .ppu2vram_data(wdata),
        .ppu2vram_wr(wr), .ppu2vram_rd(rd), .mirror_mode(mode),
        .vram2ppu_data(rdata), .vram_rd_valid(rvalid), .vram_ready(ready), .vram_err(err)
    );

    ppu_vram_responder #(.CHR_WRITABLE(1'b0), .INIT_CLEAR(1'b0), .CLEAR_VALUE(8'h00)) u_ro (
        .clock(clk), .reset(ro_rst), .ppu2vram_addr(ro_addr), .ppu2vram_data(ro_wdata),
        .ppu2vram_wr(ro_wr), .ppu2vram_rd(ro_rd), .mirror_mode(2'd0),
        .vram2ppu_data(ro_rdata), .vram_rd_valid(ro_rvalid), .vram_ready(ro_ready), .vram_err(ro_err)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [13:0] addr;
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [22];

    logic [7:0] mnt  [2048];
    logic [5:0] mpal [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [13:0] a, input logic [7:0] exp);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk({name, "_valid"}, {31'd0, rvalid}, 32'd1);
        chk(name, {24'd0, rdata}, {24'd0, exp});
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
        chk(name, n, 2048);
    endtask

    function automatic logic [10:0] m_nt(input logic [13:0] a, input logic [1:0] m);
        logic t;
        case (m)
            2'd0:    t = a[11];
            2'd1:    t = a[10];
            2'd2:    t = 1'b0;
            default: t = 1'b1;
        endcase
        return {t, a[9:0]};
    endfunction

    function automatic logic [4:0] m_pal(input logic [13:0] a);
        logic [4:0] p;
        p = a[4:0];
        if (p[1:0] == 2'b00) p[4] = 1'b0;
        return p;
    endfunction

    initial begin
        //               wr    rd    addr      data   mode  valid exp
        vecs[0]  = '{1'b1, 1'b0, 14'h2005, 8'hA5, 2'd1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 14'h2805, 8'h00, 2'd1, 1'b1, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 14'h2405, 8'h00, 2'd1, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 14'h2405, 8'h00, 2'd0, 1'b1, 8'hA5};
        vecs[4]  = '{1'b0, 1'b1, 14'h2805, 8'h00, 2'd0, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 14'h2C05, 8'h00, 2'd2, 1'b1, 8'hA5};
        vecs[6]  = '{1'b0, 1'b1, 14'h2005, 8'h00, 2'd3, 1'b1, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 14'h2C05, 8'h3C, 2'd3, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 14'h2005, 8'h00, 2'd3, 1'b1, 8'h3C};
        vecs[9]  = '{1'b0, 1'b1, 14'h3405, 8'h00, 2'd1, 1'b1, 8'h3C};
        vecs[10] = '{1'b1, 1'b0, 14'h3F10, 8'hFF, 2'd0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 14'h3F00, 8'h00, 2'd0, 1'b1, 8'h3F};
        vecs[12] = '{1'b0, 1'b1, 14'h3F30, 8'h00, 2'd0, 1'b1, 8'h3F};
        vecs[13] = '{1'b0, 1'b1, 14'h3F11, 8'h00, 2'd0, 1'b1, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 14'h3F15, 8'hC2, 2'd0, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 14'h3FF5, 8'h00, 2'd0, 1'b1, 8'h02};
        vecs[16] = '{1'b0, 1'b1, 14'h3F05, 8'h00, 2'd0, 1'b1, 8'h00};
        vecs[17] = '{1'b1, 1'b0, 14'h1234, 8'h99, 2'd0, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 1'b1, 14'h1234, 8'h00, 2'd0, 1'b1, 8'h99};
        vecs[19] = '{1'b0, 1'b1, 14'h2005, 8'h00, 2'd1, 1'b1, 8'hA5};
        vecs[20] = '{1'b1, 1'b0, 14'h3F1C, 8'h2A, 2'd0, 1'b0, 8'h00};
        vecs[21] = '{1'b0, 1'b1, 14'h3F0C, 8'h00, 2'd0, 1'b1, 8'h2A};

        // Reset state and clear duration
        repeat (3) tick();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_valid", {31'd0, rvalid}, 32'd0);
        chk("rst_data", {24'd0, rdata}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("ro_rst_ready", {31'd0, ro_ready}, 32'd1);
        rst = 1'b0;
        ro_rst = 1'b0;
        wait_ready("clear_cycles");
        do_read("clr_2000", 14'h2000, 8'h00);
        do_read("clr_27ff", 14'h27FF, 8'h00);
        do_read("clr_3f00", 14'h3F00, 8'h00);
        tick();
        chk("valid_single_pulse", {31'd0, rvalid}, 32'd0);

        // Vector table: mirroring, palette aliasing, pattern RAM, back-to-back reads
        for (int i = 0; i < 22; i++) begin
            addr = vecs[i].addr; wdata = vecs[i].data; mode = vecs[i].mode;
            wr = vecs[i].wr; rd = vecs[i].rd;
            tick();
            wr = 1'b0; rd = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'd0, rvalid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_data", i), {24'd0, rdata}, {24'd0, vecs[i].exp_data});
            end
        end
        chk("vec_err_clean", {31'd0, err}, 32'd0);

        // Simultaneous rd and wr: write wins, read dropped, error flagged
        mode = 2'd0;
        addr = 14'h2100; wdata = 8'h5A; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        chk("rdwr_no_valid", {31'd0, rvalid}, 32'd0);
        chk("rdwr_err", {31'd0, err}, 32'd1);
        do_read("rdwr_data", 14'h2100, 8'h5A);

        // Reset mid-read and mid-clear restarts the clear
        do_write(14'h2200, 8'h11);
        do_write(14'h3F01, 8'h22);
        addr = 14'h2200; rd = 1'b1; rst = 1'b1;
        tick();
        rd = 1'b0; rst = 1'b0;
        chk("rst_discards_rd", {31'd0, rvalid}, 32'd0);
        chk("rst_clears_err", {31'd0, err}, 32'd0);
        for (int k = 0; k < 1000; k++) begin
            if (k == 500) begin addr = 14'h3F07; wdata = 8'h15; wr = 1'b1; end
            if (k == 600) begin addr = 14'h2200; rd = 1'b1; end
            tick();
            if (k == 600) chk("clear_rd_ignored", {31'd0, rvalid}, 32'd0);
            wr = 1'b0; rd = 1'b0;
        end
        chk("clear_access_err", {31'd0, err}, 32'd1);
        chk("clear_not_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rerst_err", {31'd0, err}, 32'd0);
        chk("rerst_ready", {31'd0, ready}, 32'd0);
        wait_ready("reclear_cycles");
        do_read("reclr_2200", 14'h2200, 8'h00);
        do_read("reclr_3f01", 14'h3F01, 8'h00);
        do_read("clear_wr_dropped", 14'h3F07, 8'h00);
        chk("reclr_err", {31'd0, err}, 32'd0);

        // Read-only pattern build
        ro_addr = 14'h0100; ro_wdata = 8'h77; ro_wr = 1'b1;
        tick();
        ro_wr = 1'b0;
        chk("ro_err", {31'd0, ro_err}, 32'd1);
        ro_rd = 1'b1;
        tick();
        ro_rd = 1'b0;
        chk("ro_pat_valid", {31'd0, ro_rvalid}, 32'd1);
        chk("ro_pat_data", {24'd0, ro_rdata}, 32'd0);
        ro_addr = 14'h2000; ro_wdata = 8'h5C; ro_wr = 1'b1;
        tick();
        ro_wr = 1'b0; ro_rd = 1'b1;
        tick();
        ro_rd = 1'b0;
        chk("ro_nt_data", {24'd0, ro_rdata}, 32'h5C);

        // Random nametable/palette traffic against a model
        for (int i = 0; i < 2048; i++) mnt[i] = 8'h00;
        for (int i = 0; i < 32; i++) mpal[i] = 6'h00;
        for (int i = 0; i < 300; i++) begin
            logic [13:0] a;
            logic [7:0]  d, e;
            logic [1:0]  m;
            logic        w;
            a = 14'($urandom_range(32'h3FFF, 32'h2000));
            d = 8'($urandom);
            m = 2'($urandom);
            w = ($urandom_range(9, 0) < 3);
            e = (a[13:8] == 6'h3F) ? {2'b00, mpal[m_pal(a)]} : mnt[m_nt(a, m)];
            addr = a; wdata = d; mode = m; wr = w; rd = !w;
            tick();
            wr = 1'b0; rd = 1'b0;
            if (w) begin
                if (a[13:8] == 6'h3F) mpal[m_pal(a)] = d[5:0];
                else mnt[m_nt(a, m)] = d;
            end else begin
                chk($sformatf("rand%0d_valid", i), {31'd0, rvalid}, 32'd1);
                chk($sformatf("rand%0d_data@%0h", i, a), {24'd0, rdata}, {24'd0, e});
            end
        end
        chk("rand_err_clean", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
